// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the DCE-side UART receiver.
package uart_rx_pkg;

    localparam int DATA_BITS = 8;
    localparam int MIN_DBR   = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Effective bit period: requested divisor clamped to the shortest usable period.
    function automatic logic [31:0] bit_period(input logic [31:0] dbr);
        return (dbr < 32'(MIN_DBR)) ? 32'(MIN_DBR) : dbr;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO: head always presents the oldest entry, 0 when empty.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clock10M,
    input  logic                          reset,
    input  logic                          push,
    input  logic [7:0]                    push_data,
    input  logic                          pop,
    output logic [7:0]                    head,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [CW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] p);
        return (p == CW'(FIFO_DEPTH - 1)) ? '0 : p + CW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the same cycle frees a slot.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock10M or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock10M) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dce_uart_rx.sv
// DCE-side 8N1 UART receiver with show-ahead receive FIFO and cts flow control.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module dce_uart_rx
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CTS_MARGIN = 2
) (
    input  logic        clock10M,
    input  logic        reset,
    input  logic        txd,
    output logic        cts,
    input  logic [31:0] DBR,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        frame_err,
    output logic        overrun_err,
    output logic        parity_err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CTS_LIMIT = CW'(FIFO_DEPTH - CTS_MARGIN - 1);

    logic          txd_p0, txd_p1, txd_p2, txd_s;
    rx_state_t     state, state_nxt;
    logic [31:0]   cnt, cnt_nxt, period, period_nxt, p_now;
    logic [2:0]    idx, idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          fire, push_req, ferr_nxt;
    logic          fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;
`ifdef UART_RX_PARITY_EN
    logic          par, par_nxt, perr_nxt;
`endif

    // Stage p0/p1: metastability synchronizer; p2 keeps the previous txd_s for edge detection.
    always_ff @(posedge clock10M or negedge reset) begin
        if (!reset) begin
            txd_p0 <= 1'b1;
            txd_p1 <= 1'b1;
            txd_p2 <= 1'b1;
        end else begin
            txd_p0 <= txd;
            txd_p1 <= txd_p0;
            txd_p2 <= txd_p1;
        end
    end

    assign txd_s = txd_p1;
    assign p_now = bit_period(DBR);
    assign fire  = (cnt == '0);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = fire ? cnt : cnt - 32'd1;
        period_nxt = period;
        idx_nxt    = idx;
        shreg_nxt  = shreg;
        push_req   = 1'b0;
        ferr_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt    = par;
        perr_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Period is frozen here so a DBR change mid-character has no effect.
                if (txd_p2 && !txd_s) begin
                    period_nxt = p_now;
                    cnt_nxt    = (p_now >> 1) - 32'd1;
                    state_nxt  = START;
                end
            end
            START: begin
                if (fire) begin
                    if (txd_s) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt   = period - 32'd1;
                        idx_nxt   = '0;
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (fire) begin
                    shreg_nxt[idx] = txd_s;
                    cnt_nxt        = period - 32'd1;
                    idx_nxt        = idx + 3'd1;
                    if (idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (fire) begin
                    par_nxt   = txd_s;
                    cnt_nxt   = period - 32'd1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (fire) begin
                    if (txd_s) begin
`ifdef UART_RX_PARITY_EN
                        if (^{shreg, par}) perr_nxt = 1'b1;
                        else               push_req = 1'b1;
`else
                        push_req = 1'b1;
`endif
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                if (txd_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock10M or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            cts         <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            cts         <= (fifo_count <= CTS_LIMIT);
            frame_err   <= ferr_nxt;
            overrun_err <= push_req && fifo_full && !rx_ready;
        end
    end

    always_ff @(posedge clock10M) begin
        period <= period_nxt;
        shreg  <= shreg_nxt;
`ifdef UART_RX_PARITY_EN
        par    <= par_nxt;
`endif
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock10M or negedge reset) begin
        if (!reset) parity_err <= 1'b0;
        else        parity_err <= perr_nxt;
    end
`else
    assign parity_err = 1'b0;
`endif

    uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clock10M  (clock10M),
        .reset     (reset),
        .push      (push_req),
        .push_data (shreg),
        .pop       (rx_ready),
        .head      (rx_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_dce_uart_rx.sv
// Bench for dce_uart_rx: frame-level model of byte arrival plus queue-based FIFO, checked every cycle.
module tb_dce_uart_rx;
    localparam int DEPTH     = 4;
    localparam int MARGIN    = 2;
    localparam int CTS_LIMIT = DEPTH - MARGIN - 1;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic        clock10M = 1'b0;
    logic        reset;
    logic        txd;
    logic        cts;
    logic [31:0] DBR;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        frame_err;
    logic        overrun_err;
    logic        parity_err;

    dce_uart_rx #(.FIFO_DEPTH(DEPTH), .CTS_MARGIN(MARGIN)) dut (
        .clock10M    (clock10M),
        .reset       (reset),
        .txd         (txd),
        .cts         (cts),
        .DBR         (DBR),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    always #50 clock10M = ~clock10M;

    typedef enum int {EV_PUSH, EV_FERR, EV_PERR} ev_kind_t;
    typedef struct {
        int         cyc;
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    int         compared = 0;
    int         mismatched = 0;
    int         cyc = 0;
    logic       rst_at_edge = 1'b0;
    ev_t        evq[$];
    ev_t        ev;
    logic [7:0] mq[$];
    logic       exp_cts, exp_ferr, exp_ovr, exp_perr;
    logic       pop_pending = 1'b0;
    logic       prev_valid = 1'b0;
    int         rise_cyc = 0;
    int         ferr_seen = 0, ovr_seen = 0, perr_seen = 0;
    int         last_c0 = 0, last_neff = 0;
    logic [7:0] got[$];
    logic [7:0] drain_exp [4] = '{8'h22, 8'h33, 8'h44, 8'h66};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock10M) begin
        cyc = cyc + 1;
        rst_at_edge = reset;
    end

    // Model: a byte appears (or an error pulses) one cycle after its stop-bit centre.
    always @(negedge clock10M) begin
        if (!reset || !rst_at_edge) begin
            mq.delete();
            evq.delete();
            pop_pending = 1'b0;
            prev_valid  = 1'b0;
            check("rst_cts", cts, 1'b0);
            check("rst_valid", rx_valid, 1'b0);
            check("rst_data", rx_data, 8'h00);
            check("rst_ferr", frame_err, 1'b0);
            check("rst_ovr", overrun_err, 1'b0);
            check("rst_perr", parity_err, 1'b0);
        end else begin
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
            exp_perr = 1'b0;
            exp_cts  = (mq.size() <= CTS_LIMIT);
            if (pop_pending) void'(mq.pop_front());
            while (evq.size() > 0 && evq[0].cyc <= cyc) begin
                ev = evq.pop_front();
                if (ev.cyc == cyc) begin
                    case (ev.kind)
                        EV_PUSH: if (mq.size() < DEPTH) mq.push_back(ev.data); else exp_ovr = 1'b1;
                        EV_FERR: exp_ferr = 1'b1;
                        EV_PERR: exp_perr = 1'b1;
                        default: ;
                    endcase
                end
            end
            check("cts", cts, exp_cts);
            check("rx_valid", rx_valid, mq.size() > 0);
            if (mq.size() > 0) check("rx_data", rx_data, mq[0]);
            check("frame_err", frame_err, exp_ferr);
            check("overrun_err", overrun_err, exp_ovr);
            check("parity_err", parity_err, exp_perr);
            if (frame_err)   ferr_seen++;
            if (overrun_err) ovr_seen++;
            if (parity_err)  perr_seen++;
            if (rx_valid && !prev_valid) rise_cyc = cyc;
            prev_valid  = rx_valid;
            pop_pending = (mq.size() > 0) && rx_ready;
        end
    end

    task automatic hold_line(input logic v, input int n);
        txd = v;
        repeat (n) @(posedge clock10M);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stopv, input logic parv,
                              input int tail_low);
        int  p;
        ev_t e;
        p = (DBR < 4) ? 4 : int'(DBR);
        @(posedge clock10M);
        #1;
        last_c0 = cyc;
        e.cyc   = cyc + 3 + p / 2 + (FRAME_BITS - 1) * p;
        e.data  = data;
        if (!stopv)                                      e.kind = EV_FERR;
        else if (FRAME_BITS == 11 && ((^data) ^ parv))   e.kind = EV_PERR;
        else                                             e.kind = EV_PUSH;
        last_neff = e.cyc;
        evq.push_back(e);
        hold_line(1'b0, p);
        for (int i = 0; i < 8; i++) hold_line(data[i], p);
        if (FRAME_BITS == 11) hold_line(parv, p);
        hold_line(stopv, p);
        if (tail_low > 0) hold_line(1'b0, tail_low);
        hold_line(1'b1, 8);
    endtask

    task automatic pop_one();
        @(posedge clock10M);
        #1 rx_ready = 1'b1;
        @(posedge clock10M);
        #1 rx_ready = 1'b0;
    endtask

    initial begin
        #4000000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; txd = 1'b1; rx_ready = 1'b0; DBR = 32'd16;
        #5 reset = 1'b0;
        #10;
        check("lit_rst_cts", cts, 1'b0);
        check("lit_rst_valid", rx_valid, 1'b0);
        check("lit_rst_data", rx_data, 8'h00);
        repeat (3) @(negedge clock10M);
        #10 reset = 1'b1;
        repeat (3) @(posedge clock10M);
        #1 check("lit_cts_after_rst", cts, 1'b1);

        // Basic byte, P=16: valid rises 3 + 8 + 9*16 = 155 cycles after the start edge is driven.
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        check("lit_a5_valid", rx_valid, 1'b1);
        check("lit_a5_data", rx_data, 8'hA5);
        check("lit_a5_latency", rise_cyc - last_c0, 155);
        check("lit_a5_noerr", ferr_seen + ovr_seen + perr_seen, 0);
        pop_one();

        // Start-bit glitch of 6 cycles is rejected at the mid-bit check.
        hold_line(1'b0, 6);
        hold_line(1'b1, 40);
        check("lit_glitch_valid", rx_valid, 1'b0);
        check("lit_glitch_ferr", ferr_seen, 0);
        send_frame(8'h3C, 1'b1, 1'b0, 0);
        check("lit_3c_data", rx_data, 8'h3C);
        pop_one();

        // Framing error then break, P=20.
        DBR = 32'd20;
        send_frame(8'h55, 1'b0, 1'b0, 100);
        check("lit_break_ferr", ferr_seen, 1);
        check("lit_break_empty", rx_valid, 1'b0);
        send_frame(8'h12, 1'b1, 1'b0, 0);
        check("lit_12_data", rx_data, 8'h12);
        pop_one();

        // DBR below the minimum runs at P=4.
        DBR = 32'd2;
        send_frame(8'h96, 1'b1, 1'b0, 0);
        check("lit_96_data", rx_data, 8'h96);
        pop_one();
        DBR = 32'd16;

        // Fill to depth 4 with no consumer, then overrun.
        send_frame(8'h11, 1'b1, 1'b0, 0);
        send_frame(8'h22, 1'b1, 1'b0, 0);
        check("lit_cts_low", cts, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0, 0);
        send_frame(8'h44, 1'b1, 1'b0, 0);
        send_frame(8'h99, 1'b1, 1'b0, 0);
        check("lit_ovr_count", ovr_seen, 1);
        check("lit_ovr_head", rx_data, 8'h11);

        // Full FIFO, pop on exactly the push cycle: byte accepted.
        fork
            send_frame(8'h66, 1'b1, 1'b0, 0);
            begin
                @(posedge clock10M);
                #2;
                while (cyc != last_neff - 1) begin
                    @(posedge clock10M);
                    #1;
                end
                rx_ready = 1'b1;
                @(posedge clock10M);
                #1 rx_ready = 1'b0;
            end
        join
        check("lit_edge_ovr_count", ovr_seen, 1);
        check("lit_edge_head", rx_data, 8'h22);

        // Drain in order.
        got.delete();
        rx_ready = 1'b1;
        for (int i = 0; i < 12 && got.size() < 4; i++) begin
            @(negedge clock10M);
            if (rx_valid) got.push_back(rx_data);
        end
        @(posedge clock10M);
        #1 rx_ready = 1'b0;
        check("lit_drain_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < got.size()) check("lit_drain_byte", got[i], drain_exp[i]);
        repeat (2) @(posedge clock10M);
        #1;
        check("lit_drain_cts", cts, 1'b1);
        check("lit_drain_empty", rx_valid, 1'b0);

        // Reset in the middle of 0x81's data bits, with a byte already buffered.
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        hold_line(1'b0, 16);
        hold_line(1'b1, 16);
        hold_line(1'b0, 8);
        #3 reset = 1'b0;
        #1;
        check("lit_async_valid", rx_valid, 1'b0);
        check("lit_async_cts", cts, 1'b0);
        check("lit_async_data", rx_data, 8'h00);
        txd = 1'b1;
        repeat (3) @(negedge clock10M);
        #10 reset = 1'b1;
        hold_line(1'b1, 20);
        send_frame(8'h7E, 1'b1, 1'b0, 0);
        check("lit_7e_data", rx_data, 8'h7E);
        check("lit_7e_valid", rx_valid, 1'b1);
        pop_one();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 0);
        check("lit_par_bad_count", perr_seen, 1);
        check("lit_par_bad_empty", rx_valid, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 0);
        check("lit_par_ok_data", rx_data, 8'h07);
        pop_one();
`endif

        repeat (4) @(posedge clock10M);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dce_uart_rx.md
Name: dce_uart_rx

Overview:
DCE-side UART receiver: the device end that deserializes the character stream the DTE transactor drives on txd.
- Line format is 8N1, LSB first, bit period of DBR clock cycles.
- Received bytes are buffered in a FIFO and presented on a valid/ready stream to DCE logic.
- Drives cts for hardware flow control back to the DTE.
- Sits beside the loopback DCE in the wrapper as the standalone receive half.

Parameters:
FIFO_DEPTH, 16, receive FIFO entries; power of two, minimum 4.
CTS_MARGIN, 2, free entries that must remain before cts drops (covers a character already in flight).

Ports:
clock10M  in  1  system clock, 10 MHz.
reset  in  1  asynchronous, active-low reset.
txd  in  1  serial data from the DTE; idles high.
cts  out  1  1 = DTE may transmit.
DBR  in  32  bit period in clock10M cycles; values below 4 are treated as 4.
rx_data  out  8  FIFO head byte.
rx_valid  out  1  FIFO not empty.
rx_ready  in  1  consumer accepts rx_data when rx_valid is also high.
frame_err  out  1  one-cycle pulse: stop bit sampled low.
overrun_err  out  1  one-cycle pulse: byte dropped because the FIFO was full.
parity_err  out  1  one-cycle pulse: parity mismatch; tied 0 without the optional feature.

Behaviour:
- Reset (reset low, asynchronous):
  - Outputs: cts=0, rx_valid=0, rx_data=0, all error pulses 0.
  - Internal: FIFO emptied, FSM in IDLE, synchronizer flops set to 1.
- Input sync: txd passes through a 2-flop synchronizer; all logic below uses the synchronized value (txd_s).
- Bit period: P = max(DBR, 4). DBR is sampled at the start-bit edge and held constant for that whole character.
- Counter: 32-bit down-counter; loaded with P-1 (or P/2-1); fires when it reaches 0.
- FSM states and transitions:
  - IDLE: on a falling edge of txd_s, load P/2-1 and go to START.
  - START (mid-bit check): on fire, if txd_s=1 it was a glitch, so go to IDLE with no error. Otherwise load P-1, clear the bit index, go to DATA.
  - DATA: on each fire, shift txd_s into bit[index] (LSB first) and reload P-1. After index 7, go to PARITY if the feature is enabled, else STOP.
  - STOP: on fire, sample txd_s.
    - If 1: push the byte (subject to FIFO rules below) and go to IDLE.
    - If 0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait for txd_s=1, then go to IDLE. No start detection while in BREAK.
- FIFO: show-ahead.
  - rx_data is always the head entry; rx_valid = !empty.
  - Pop occurs when rx_valid && rx_ready.
- Push timing: a byte pushed at the stop mid-sample on cycle N is visible on rx_valid/rx_data at N+1.
- Full boundary: a push is accepted when not full, or when full and a pop occurs in the same cycle. Otherwise pulse overrun_err, drop the byte, and leave the FIFO contents unchanged.
- Push and pop together when empty: the push wins; the pop has no effect because rx_valid was 0.
- cts is registered: cts = (count <= FIFO_DEPTH-CTS_MARGIN-1) evaluated each cycle, so it updates 1 cycle after a count change.
- cts dropping mid-character does not abort reception; that character completes normally.
- Pointer and count widths: $clog2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - A PARITY state sits between DATA and STOP and samples a 9th bit one period P after bit 7.
  - Parity is even: the XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch: pulse parity_err at the STOP fire, discard the byte, return to IDLE (a frame error in the same character takes priority).
- Not defined: the PARITY state is absent, the frame is 10 bits, and parity_err is constant 0.

Decomposition:
- Package uart_rx_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - DATA_BITS=8, MIN_DBR=4.
- Sub-module uart_rx_fifo: synchronous show-ahead FIFO, parameter FIFO_DEPTH.
  - Ports: push, push_data, pop, head, empty, full, count.
  - Same clock10M and reset as the parent.

Test Plan:
- DBR=16, DTE sends 0xA5 as 8N1 → rx_valid rises 1 cycle after the stop mid-sample, rx_data=0xA5, no error pulses.
- DBR=16, txd low for 6 cycles then high → no byte, no error, FSM back in IDLE; a following 0x3C is received correctly.
- DBR=20, 0x55 sent with stop bit forced low, then line held low 100 cycles → frame_err pulses once, FIFO empty. The next 0x12 is received only after txd returns high.
- FIFO_DEPTH=4, CTS_MARGIN=2, rx_ready=0:
  - cts drops after the 2nd byte is buffered.
  - 5 bytes forced → 4 buffered, overrun_err pulses on the 5th.
  - Raising rx_ready drains 4 bytes in order and cts returns high.
- Full FIFO with rx_ready=1 on the exact cycle of the 5th stop sample → no overrun, byte appended, count stays 4.
- Assert reset mid-DATA of byte 0x81 → outputs go to reset values immediately; after release a clean 0x7E is received.
- With UART_RX_PARITY_EN: 0x07 with parity bit 0 → parity_err pulse, byte dropped; 0x07 with parity bit 1 → accepted.
